// File: rtl/br_perf_pkg.sv
// br_perf_pkg
//   Shared definitions for the branch-predictor performance monitor:
//   FSM state encoding and default parameter values used by
//   br_perf_monitor and br_perf_cnt.
package br_perf_pkg;

    localparam int unsigned BR_PERF_NUM_CH_DEF  = 4;
    localparam int unsigned BR_PERF_CNT_W_DEF   = 32;
    localparam int unsigned BR_PERF_WIN_LEN_DEF = 1024;
    localparam int unsigned BR_PERF_SAT_EN_DEF  = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/br_perf_cnt.sv
// br_perf_cnt
//   Single event counter, CNT_W wide, saturating (SAT_EN=1) or wrapping
//   (SAT_EN=0).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : load zero at the next edge (overrides inc)
//   inc        : count one event this cycle
//   cnt        : current registered count
//   cnt_nxt    : count including this cycle's event (value a snapshot takes)
module br_perf_cnt
    import br_perf_pkg::*;
#(
    parameter int unsigned CNT_W  = BR_PERF_CNT_W_DEF,
    parameter int unsigned SAT_EN = BR_PERF_SAT_EN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    logic hold;

    assign hold = (SAT_EN != 0) && (cnt == '1);

    always_comb begin
        cnt_nxt = cnt;
        if (inc && !hold) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // clr wins over inc so a window can restart with the current cycle's
    // event already captured through cnt_nxt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/br_perf_monitor.sv
// br_perf_monitor
//   Counts cycles, instructions, and per-channel branches / mispredicts
//   while running, and publishes snapshots through a valid/ready register
//   stage either at the end of each WIN_LEN-cycle window or on stop.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i, stop_i      : control pulses (stop wins when both are high)
//   instr_vld_i          : one instruction fetched this cycle
//   br_instr_i/br_miss_i : per-channel branch resolved / mispredicted
//   snap_vld_o/snap_rdy_i: snapshot handshake
//   snap_*_o             : snapshot counts
//   busy_o               : monitor is running
//   ovr_o                : sticky, a snapshot was dropped
//   proto_err_o          : sticky, a miss arrived without a branch
module br_perf_monitor
    import br_perf_pkg::*;
#(
    parameter int unsigned NUM_CH  = BR_PERF_NUM_CH_DEF,
    parameter int unsigned CNT_W   = BR_PERF_CNT_W_DEF,
    parameter int unsigned WIN_LEN = BR_PERF_WIN_LEN_DEF,
    parameter int unsigned SAT_EN  = BR_PERF_SAT_EN_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          instr_vld_i,
    input  logic [NUM_CH-1:0]             br_instr_i,
    input  logic [NUM_CH-1:0]             br_miss_i,
    output logic                          snap_vld_o,
    input  logic                          snap_rdy_i,
    output logic [CNT_W-1:0]              snap_cyc_o,
    output logic [CNT_W-1:0]              snap_instr_o,
    output logic [NUM_CH-1:0][CNT_W-1:0]  snap_br_o,
    output logic [NUM_CH-1:0][CNT_W-1:0]  snap_miss_o,
    output logic                          busy_o,
    output logic                          ovr_o,
    output logic                          proto_err_o
);

    localparam logic [CNT_W-1:0] WIN_LAST = (WIN_LEN == 0) ? '0 : CNT_W'(WIN_LEN - 1);

    state_e state;
    state_e state_nxt;

    logic start_acc;
    logic cnt_run;
    logic offer;
    logic win_end;
    logic cnt_clr;
    logic drop;
    logic proto_hit;

    logic [CNT_W-1:0]             cyc_cnt;
    logic [CNT_W-1:0]             cyc_nxt;
    logic [CNT_W-1:0]             instr_cnt;
    logic [CNT_W-1:0]             instr_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0] br_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] br_nxt;
    logic [NUM_CH-1:0][CNT_W-1:0] miss_cnt;
    logic [NUM_CH-1:0][CNT_W-1:0] miss_nxt;
    logic                         unused_cnt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_i && !stop_i) state_nxt = ST_RUN;
            ST_RUN:  if (stop_i)             state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o    = 1'b0;
        start_acc = 1'b0;
        cnt_run   = 1'b0;
        offer     = 1'b0;
        case (state)
            ST_IDLE: start_acc = start_i && !stop_i;
            ST_RUN: begin
                busy_o  = 1'b1;
                cnt_run = 1'b1;
                offer   = stop_i || win_end;
            end
            default: ;
        endcase
    end

    // ---------------- counters ----------------
    assign win_end = (WIN_LEN != 0) && (cyc_cnt == WIN_LAST);
    assign cnt_clr = start_acc || (cnt_run && win_end);

    br_perf_cnt #(.CNT_W(CNT_W), .SAT_EN(SAT_EN)) u_cyc_cnt (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (cnt_clr),
        .inc     (cnt_run),
        .cnt     (cyc_cnt),
        .cnt_nxt (cyc_nxt)
    );

    br_perf_cnt #(.CNT_W(CNT_W), .SAT_EN(SAT_EN)) u_instr_cnt (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .clr     (cnt_clr),
        .inc     (cnt_run && instr_vld_i),
        .cnt     (instr_cnt),
        .cnt_nxt (instr_nxt)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        br_perf_cnt #(.CNT_W(CNT_W), .SAT_EN(SAT_EN)) u_br_cnt (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .clr     (cnt_clr),
            .inc     (cnt_run && br_instr_i[c]),
            .cnt     (br_cnt[c]),
            .cnt_nxt (br_nxt[c])
        );

        br_perf_cnt #(.CNT_W(CNT_W), .SAT_EN(SAT_EN)) u_miss_cnt (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .clr     (cnt_clr),
            .inc     (cnt_run && br_instr_i[c] && br_miss_i[c]),
            .cnt     (miss_cnt[c]),
            .cnt_nxt (miss_nxt[c])
        );
    end

    // Only the cycle counter's registered value is needed (window compare);
    // the others are published through their cnt_nxt view.
    assign unused_cnt = ^{instr_cnt, br_cnt, miss_cnt};

    // ---------------- snapshot stage and sticky flags ----------------
    assign drop      = offer && snap_vld_o && !snap_rdy_i;
    assign proto_hit = |(br_miss_i & ~br_instr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snap_vld_o   <= 1'b0;
            snap_cyc_o   <= '0;
            snap_instr_o <= '0;
            snap_br_o    <= '0;
            snap_miss_o  <= '0;
            ovr_o        <= 1'b0;
            proto_err_o  <= 1'b0;
        end else begin
            if (offer && (!snap_vld_o || snap_rdy_i)) begin
                snap_vld_o   <= 1'b1;
                snap_cyc_o   <= cyc_nxt;
                snap_instr_o <= instr_nxt;
                snap_br_o    <= br_nxt;
                snap_miss_o  <= miss_nxt;
            end else if (snap_vld_o && snap_rdy_i) begin
                snap_vld_o <= 1'b0;
            end
            // A protocol error seen in the start cycle itself survives the clear.
            ovr_o       <= (ovr_o && !start_acc) || drop;
            proto_err_o <= (proto_err_o && !start_acc) || proto_hit;
        end
    end

endmodule

// File: tb/tb_br_perf_monitor.sv
// tb_br_perf_monitor
//   Directed bench driving four parameterisations of br_perf_monitor from
//   shared stimulus; each scenario checks the instance it targets.
module tb_br_perf_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       instr_vld;
    logic [1:0] br_instr;
    logic [1:0] br_miss;
    logic       snap_rdy;

    int n_checks = 0;
    int n_errors = 0;

    // a: windowed (8), 32-bit
    logic            a_vld, a_busy, a_ovr, a_proto;
    logic [31:0]     a_cyc, a_instr;
    logic [1:0][31:0] a_br, a_miss;
    // b: free-running, 4-bit, saturating
    logic            b_vld, b_busy, b_ovr, b_proto;
    logic [3:0]      b_cyc, b_instr;
    logic [1:0][3:0] b_br, b_miss;
    // c: free-running, 4-bit, wrapping
    logic            c_vld, c_busy, c_ovr, c_proto;
    logic [3:0]      c_cyc, c_instr;
    logic [1:0][3:0] c_br, c_miss;
    // d: windowed (4), 16-bit
    logic             d_vld, d_busy, d_ovr, d_proto;
    logic [15:0]      d_cyc, d_instr;
    logic [1:0][15:0] d_br, d_miss;

    always #5 clk = ~clk;

    br_perf_monitor #(.NUM_CH(2), .CNT_W(32), .WIN_LEN(8), .SAT_EN(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .instr_vld_i(instr_vld), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .snap_vld_o(a_vld), .snap_rdy_i(snap_rdy), .snap_cyc_o(a_cyc),
        .snap_instr_o(a_instr), .snap_br_o(a_br), .snap_miss_o(a_miss),
        .busy_o(a_busy), .ovr_o(a_ovr), .proto_err_o(a_proto)
    );

    br_perf_monitor #(.NUM_CH(2), .CNT_W(4), .WIN_LEN(0), .SAT_EN(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .instr_vld_i(instr_vld), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .snap_vld_o(b_vld), .snap_rdy_i(snap_rdy), .snap_cyc_o(b_cyc),
        .snap_instr_o(b_instr), .snap_br_o(b_br), .snap_miss_o(b_miss),
        .busy_o(b_busy), .ovr_o(b_ovr), .proto_err_o(b_proto)
    );

    br_perf_monitor #(.NUM_CH(2), .CNT_W(4), .WIN_LEN(0), .SAT_EN(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .instr_vld_i(instr_vld), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .snap_vld_o(c_vld), .snap_rdy_i(snap_rdy), .snap_cyc_o(c_cyc),
        .snap_instr_o(c_instr), .snap_br_o(c_br), .snap_miss_o(c_miss),
        .busy_o(c_busy), .ovr_o(c_ovr), .proto_err_o(c_proto)
    );

    br_perf_monitor #(.NUM_CH(2), .CNT_W(16), .WIN_LEN(4), .SAT_EN(1)) u_d (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .instr_vld_i(instr_vld), .br_instr_i(br_instr), .br_miss_i(br_miss),
        .snap_vld_o(d_vld), .snap_rdy_i(snap_rdy), .snap_cyc_o(d_cyc),
        .snap_instr_o(d_instr), .snap_br_o(d_br), .snap_miss_o(d_miss),
        .busy_o(d_busy), .ovr_o(d_ovr), .proto_err_o(d_proto)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start     = 1'b0;
        stop      = 1'b0;
        instr_vld = 1'b0;
        br_instr  = 2'b00;
        br_miss   = 2'b00;
        snap_rdy  = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        #2;
        // reset state
        check("rst_a_busy",  32'(a_busy),  0);
        check("rst_a_vld",   32'(a_vld),   0);
        check("rst_a_cyc",   a_cyc,        0);
        check("rst_d_ovr",   32'(d_ovr),   0);
        check("rst_d_proto", 32'(d_proto), 0);
        do_reset();

        // ---- windows of 8 on u_a: br=11, miss=01 every cycle ----
        snap_rdy  = 1'b1;
        br_instr  = 2'b11;
        br_miss   = 2'b01;
        instr_vld = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        check("win_busy", 32'(a_busy), 1);
        repeat (7) tick();
        check("win_vld_early", 32'(a_vld), 0);
        tick();
        check("win1_vld",   32'(a_vld),     1);
        check("win1_cyc",   a_cyc,          8);
        check("win1_instr", a_instr,        8);
        check("win1_br0",   a_br[0],        8);
        check("win1_br1",   a_br[1],        8);
        check("win1_miss0", a_miss[0],      8);
        check("win1_miss1", a_miss[1],      0);
        check("win1_proto", 32'(a_proto),   0);
        tick();
        check("win1_consumed", 32'(a_vld), 0);
        repeat (7) tick();
        check("win2_vld",   32'(a_vld), 1);
        check("win2_cyc",   a_cyc,      8);
        check("win2_miss0", a_miss[0],  8);
        // stop right after a window: back-to-back load keeps vld high
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(a_busy), 0);
        check("stop_vld",  32'(a_vld),  1);
        check("stop_cyc",  a_cyc,       1);
        check("stop_br1",  a_br[1],     1);
        tick();
        check("stop_consumed", 32'(a_vld), 0);

        // ---- saturation vs wrap on u_b / u_c ----
        do_reset();
        start = 1'b1;
        tick();
        start     = 1'b0;
        instr_vld = 1'b1;
        repeat (20) tick();
        check("free_no_snap", 32'(b_vld), 0);
        instr_vld = 1'b0;
        stop      = 1'b1;
        tick();
        stop = 1'b0;
        check("sat_vld",   32'(b_vld), 1);
        check("sat_instr", 32'(b_instr), 15);
        check("sat_cyc",   32'(b_cyc),   15);
        check("wrap_instr", 32'(c_instr), 4);
        check("wrap_cyc",   32'(c_cyc),   5);

        // ---- overrun with windows of 4 on u_d ----
        do_reset();
        snap_rdy  = 1'b0;
        instr_vld = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("ovr_vld_early", 32'(d_vld), 0);
        tick();
        check("ovr_vld1",   32'(d_vld),   1);
        check("ovr_cyc1",   32'(d_cyc),   4);
        check("ovr_instr1", 32'(d_instr), 4);
        check("ovr_flag0",  32'(d_ovr),   0);
        repeat (4) tick();
        check("ovr_flag1", 32'(d_ovr), 1);
        check("ovr_hold_vld", 32'(d_vld), 1);
        check("ovr_hold_cyc", 32'(d_cyc), 4);
        repeat (2) tick();
        snap_rdy = 1'b1;
        tick();
        check("ovr_release_vld", 32'(d_vld), 0);
        check("ovr_sticky",      32'(d_ovr), 1);

        // ---- protocol error: miss without branch on channel 1 ----
        br_miss  = 2'b10;
        br_instr = 2'b00;
        tick();
        br_miss = 2'b00;
        check("proto_set",   32'(d_proto),   1);
        check("proto_vld",   32'(d_vld),     1);
        check("proto_miss1", 32'(d_miss[1]), 0);
        repeat (3) tick();
        check("proto_sticky", 32'(d_proto), 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("proto_after_stop", 32'(d_proto), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_busy",  32'(d_busy),  1);
        check("restart_proto", 32'(d_proto), 0);
        check("restart_ovr",   32'(d_ovr),   0);

        // ---- start and stop together ----
        start = 1'b1;
        stop  = 1'b1;
        tick();
        check("both_run_busy", 32'(d_busy), 0);
        check("both_run_vld",  32'(d_vld),  1);
        check("both_run_cyc",  32'(d_cyc),  1);
        tick();
        check("both_idle_busy", 32'(d_busy), 0);
        check("both_idle_vld",  32'(d_vld),  0);
        start = 1'b0;
        stop  = 1'b0;

        // ---- asynchronous reset mid-window with a pending snapshot ----
        do_reset();
        snap_rdy  = 1'b0;
        instr_vld = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("arst_pre_vld", 32'(a_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_vld",   32'(a_vld),   0);
        check("arst_cyc",   a_cyc,        0);
        check("arst_instr", a_instr,      0);
        check("arst_busy",  32'(a_busy),  0);
        check("arst_br0",   a_br[0],      0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("arst_post_busy", 32'(a_busy), 0);
        check("arst_post_vld",  32'(a_vld),  0);
        repeat (10) tick();
        check("arst_no_snap", 32'(a_vld),  0);
        check("arst_idle",    32'(a_busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
